// File: rtl/cnt8_dn_timer.sv
// Loadable down-counter/timer with one-shot or periodic terminal-count pulse.
// Latency: the tc pulse appears on the edge after the count sits at 1 with enable high.
// No backpressure: the counter advances on every enabled cycle while in RUN.
module cnt8_dn_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             running,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Timer FSM: reset > clear > load > count, with running/expired registered alongside state
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt_out    <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      state      <= IDLE;
      running    <= 1'b0;
      expired    <= 1'b0;
    end else if (clear) begin
      // reload_reg is deliberately left alone so software need not reprogram it
      cnt_out <= '0;
      tc      <= 1'b0;
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (load) begin
      reload_reg <= load_val;
      cnt_out    <= load_val;
      tc         <= 1'b0;
      expired    <= 1'b0;
      if (load_val != '0) begin
        state   <= RUN;
        running <= 1'b1;
      end else begin
        // a zero start value has nothing to count, so stay parked
        state   <= IDLE;
        running <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (enable) begin
            if (cnt_out > WIDTH'(1)) begin
              cnt_out <= cnt_out - WIDTH'(1);
            end else if (cnt_out == WIDTH'(1)) begin
              tc <= 1'b1;
              if (auto_reload) begin
                // reload_reg is non-zero here: RUN is only entered with a non-zero load
                cnt_out <= reload_reg;
              end else begin
                cnt_out <= '0;
                state   <= EXPIRED;
                running <= 1'b0;
                expired <= 1'b1;
              end
            end
            // cnt_out==0 cannot occur in RUN; holding keeps 0-1 from ever happening
          end
        end
        default: begin
          // IDLE and EXPIRED hold the count; enable is ignored
        end
      endcase
    end
  end

endmodule
